button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/video_delay_pkg.sv | 30 +++
 rtl/button_debouncer.sv | 148 ++++++++++++++
 tb/tb_button_debouncer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/video_delay_pkg.sv
// Purpose: shared FSM state encoding and default timing constants for the button debouncer.
// Latency: n/a (types, constants and a constant helper function only).
// Backpressure: n/a.
package video_delay_pkg;

  // Debouncer FSM states. IDLE must stay at encoding 0 so the reset value reads as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } db_state_t;

  // Default timing, in clk cycles.
  localparam int   DEF_DEBOUNCE_CYCLES      = 1_000_000;
  localparam int   DEF_REPEAT_DELAY_CYCLES  = 50_000_000;
  localparam int   DEF_REPEAT_PERIOD_CYCLES = 10_000_000;
  localparam logic DEF_ACTIVE_LOW           = 1'b0;

  // Largest of three values; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Purpose: debounce a synchronized button level; emit press/release strobes and auto-repeat while held.
// Latency: press/release accepted on the edge after DEBOUNCE_CYCLES further stable samples; all outputs registered.
// Backpressure: none; strobes are one-cycle pulses that cannot be stalled.
//
// Ports:
//   clk           block clock
//   resetn        asynchronous active-low reset
//   signal_in     raw button level, already synchronized to clk
//   level_out     debounced pressed level (1 = pressed)
//   press_pulse   one-cycle strobe on accepted press
//   release_pulse one-cycle strobe on accepted release
//   repeat_pulse  one-cycle auto-repeat strobe while held
module button_debouncer
  import video_delay_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int   REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int   REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter logic ACTIVE_LOW           = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic resetn,
  input  logic signal_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  // One extra bit of headroom so the counter never wraps before any terminal count.
  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_repeat;

  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_repeat_nxt;
  logic             w_pressed;

  assign w_pressed = signal_in ^ ACTIVE_LOW;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_repeat  <= w_repeat_nxt;
    end
  end

  // Every transition clears the shared counter; staying in a timed state advances it.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_cnt_inc;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_repeat_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_pressed) w_state_nxt = ST_PRESS_WAIT;
      end

      ST_PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_TC) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end
      end

      // Release is checked first so a repeat terminal count on the release cycle yields no pulse.
      ST_HELD: begin
        if (!w_pressed) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DLY_TC) begin
          w_state_nxt  = ST_REPEAT;
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end
      end

      ST_REPEAT: begin
        if (!w_pressed) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PER_TC) begin
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end
      end

      // A bounce back to pressed returns to HELD, restarting the full repeat delay silently.
      ST_RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_TC) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level_out     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;

endmodule

// File: tb/tb_button_debouncer.sv
// Purpose: directed self-checking bench for button_debouncer (DEBOUNCE=4, DELAY=10, PERIOD=3).
// Latency: edge k below is the k-th clock edge sampling the test's input; a press first sampled
// at edge 1 is accepted at edge 5, a release first sampled at edge r is accepted at edge r+4.
// Backpressure: n/a.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic signal_in = 1'b0;
  logic sig_al = 1'b1;

  logic level_out, press_pulse, release_pulse, repeat_pulse;
  logic al_level, al_press, al_release, al_repeat;

  logic [3:0] obs;
  logic [3:0] obs_al;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_PERIOD_CYCLES(3),
    .ACTIVE_LOW          (1'b0)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signal_in    (signal_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_PERIOD_CYCLES(3),
    .ACTIVE_LOW          (1'b1)
  ) dut_al (
    .clk          (clk),
    .resetn       (resetn),
    .signal_in    (sig_al),
    .level_out    (al_level),
    .press_pulse  (al_press),
    .release_pulse(al_release),
    .repeat_pulse (al_repeat)
  );

  // Output vector: {level, press, release, repeat}
  assign obs    = {level_out, press_pulse, release_pulse, repeat_pulse};
  assign obs_al = {al_level, al_press, al_release, al_repeat};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive both inputs, then move to 1 time unit after the next rising edge.
  task automatic step(input logic in, input logic in_al);
    signal_in = in;
    sig_al    = in_al;
    @(posedge clk);
    #1;
  endtask

  // Press sampled on edges 1..6, released from edge 7: press at 5, release at 11.
  function automatic logic [3:0] exp_short(input int i);
    return {(i >= 5 && i <= 10), (i == 5), (i == 11), 1'b0};
  endfunction

  initial begin
    logic [3:0] e;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", obs, 4'b0000);
    chk("rst_state_al", obs_al, 4'b0000);
    #2 resetn = 1'b1;
    step(1'b0, 1'b1);
    chk("idle", obs, 4'b0000);

    // Clean press, short hold, no repeat, then debounced release
    for (int i = 1; i <= 12; i++) begin
      step(i <= 6, 1'b1);
      chk($sformatf("clean[%0d]", i), obs, exp_short(i));
    end

    // Glitch 1,1,1,0 then low: nothing is accepted
    for (int i = 1; i <= 8; i++) begin
      step(i <= 3, 1'b1);
      chk($sformatf("glitch[%0d]", i), obs, 4'b0000);
    end

    // Hold through edge 30: press 5, repeats 15,18,21,24,27,30; release 35
    for (int i = 1; i <= 37; i++) begin
      step(i <= 30, 1'b1);
      e = {(i >= 5 && i <= 34), (i == 5), (i == 35),
           (i == 15 || i == 18 || i == 21 || i == 24 || i == 27 || i == 30)};
      chk($sformatf("hold30[%0d]", i), obs, e);
    end

    // Low bounce at edges 13,14 while held: no release, repeat delay restarts at 15 -> repeat 25
    for (int i = 1; i <= 32; i++) begin
      step((i <= 12) || (i >= 15 && i <= 26), 1'b1);
      e = {(i >= 5 && i <= 30), (i == 5), (i == 31), (i == 25)};
      chk($sformatf("bounce[%0d]", i), obs, e);
    end

    // Reach REPEAT (first repeat at edge 15), then reset asynchronously
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 1'b1);
      e = {(i >= 5), (i == 5), 1'b0, (i == 15)};
      chk($sformatf("pre_rst[%0d]", i), obs, e);
    end
    #2 resetn = 1'b0;
    #1;
    chk("rst_async", obs, 4'b0000);
    chk("rst_async_al", obs_al, 4'b0000);
    for (int i = 1; i <= 2; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("rst_hold[%0d]", i), obs, 4'b0000);
    end
    #2 resetn = 1'b1;

    // Button already pressed at reset release: full debounce, then press
    for (int i = 1; i <= 12; i++) begin
      step(i <= 6, 1'b1);
      chk($sformatf("post_rst[%0d]", i), obs, exp_short(i));
    end

    // Active-low instance: signal_in low means pressed
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, !(i <= 6));
      chk($sformatf("act_low[%0d]", i), obs_al, exp_short(i));
      chk($sformatf("act_low_other[%0d]", i), obs, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
